// File: rtl/systolic_array_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_if
// Description : Operand and result bus of the systolic MAC array.
//               The master drives the pre-skewed operands; the slave is the array.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 4
);
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_left;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_top;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_bot;

  modport master (
    output in_left,
    output in_top,
    input  out_bot
  );

  modport slave (
    input  in_left,
    input  in_top,
    output out_bot
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array
// Description : ARRAY_SIZE x ARRAY_SIZE output-stationary multiply-accumulate
//               array; the bottom-row accumulators drive out_bot directly.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_array_if.slave      sa_if
);

  // Per-PE register outputs, collected so neighbours and the output can tap them.
  logic [DATA_WIDTH-1:0] a_fwd   [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] b_fwd   [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] acc_fwd [ARRAY_SIZE][ARRAY_SIZE];

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
      logic [DATA_WIDTH-1:0] w_a_in;
      logic [DATA_WIDTH-1:0] w_b_in;
      logic [DATA_WIDTH-1:0] acc_d;
      logic [DATA_WIDTH-1:0] a_q;
      logic [DATA_WIDTH-1:0] b_q;
      logic [DATA_WIDTH-1:0] acc_q;

      if (j == 0) begin : g_a_edge
        assign w_a_in = sa_if.in_left[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_a_chain
        assign w_a_in = a_fwd[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign w_b_in = sa_if.in_top[j*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_b_chain
        assign w_b_in = b_fwd[i-1][j];
      end

      // Product and sum are both evaluated at DATA_WIDTH, so overflow wraps.
      assign acc_d = acc_q + w_a_in * w_b_in;

      always_ff @(posedge clk) begin
        if (!reset) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= w_a_in;
          b_q   <= w_b_in;
          acc_q <= acc_d;
        end
      end

      assign a_fwd[i][j]   = a_q;
      assign b_fwd[i][j]   = b_q;
      assign acc_fwd[i][j] = acc_q;
    end
  end

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_out
    assign sa_if.out_bot[j*DATA_WIDTH +: DATA_WIDTH] = acc_fwd[ARRAY_SIZE-1][j];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array
// Description : Directed, table-driven bench for the 4x4, 4-bit systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int W  = N*DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];

  systolic_array_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) bus ();

  systolic_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .sa_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [W-1:0] left;
    logic [W-1:0] top;
    logic [W-1:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: out_bot=%h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic [W-1:0] l, input logic [W-1:0] t);
    @(negedge clk);
    reset       = rst_n;
    bus.in_left = l;
    bus.in_top  = t;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] left_at(input int e);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (e - i >= 0 && e - i < N) v[i*DW +: DW] = a_m[i][e-i];
    return v;
  endfunction

  function automatic logic [W-1:0] top_at(input int e);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (e - j >= 0 && e - j < N) v[j*DW +: DW] = b_m[e-j][j];
    return v;
  endfunction

  task automatic skew_edge(input int e);
    step(1'b1, left_at(e), top_at(e));
  endtask

  task automatic clear();
    step(1'b0, '0, '0);
  endtask

  vec_t vecs [13];
  logic [DW-1:0] slice_exp [N];

  initial begin
    bus.in_left = '0;
    bus.in_top  = '0;

    // Reset hold, release, then the single product path from E0 to E5.
    vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 16'h0000, 16'h0003, 16'h0000};
    vecs[5]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 16'h2000, 16'h0000, 16'h0006};
    vecs[8]  = '{1'b1, 16'h0000, 16'h0000, 16'h0006};
    vecs[9]  = '{1'b1, 16'h0000, 16'h0000, 16'h0006};
    vecs[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[11] = '{1'b1, 16'h1111, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 16'h0000, 16'h0000, 16'h0000};

    for (int v = 0; v < 13; v++) begin
      step(vecs[v].rst_n, vecs[v].left, vecs[v].top);
      check($sformatf("vec%0d", v), bus.out_bot, vecs[v].exp_out);
    end

    // Skewed matmul: A all ones, B[k][j] = j.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = 4'd1;
        b_m[r][c] = DW'(c);
      end
    slice_exp[0] = 4'd0; slice_exp[1] = 4'd4; slice_exp[2] = 4'd8; slice_exp[3] = 4'd12;
    clear();
    for (int e = 0; e < 3*N-2; e++) begin
      skew_edge(e);
      if (e >= 2*(N-1)) begin
        n_checks++;
        if (bus.out_bot[(e-2*(N-1))*DW +: DW] !== slice_exp[e-2*(N-1)]) begin
          n_errors++;
          $display("FAIL matmul_slice%0d: got %h expected %h", e-2*(N-1),
                   bus.out_bot[(e-2*(N-1))*DW +: DW], slice_exp[e-2*(N-1)]);
        end
      end
    end
    check("matmul_final", bus.out_bot, 16'hC840);
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check("matmul_stable", bus.out_bot, 16'hC840);

    // Second run without reset accumulates on top of the first.
    for (int e = 0; e < 3*N-2; e++) skew_edge(e);
    check("accumulate_twice", bus.out_bot, 16'h8080);

    // Wrap-around: A all ones, B all 5.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) b_m[r][c] = 4'd5;
    clear();
    check("wrap_reset", bus.out_bot, 16'h0000);
    for (int e = 0; e < 3*N-2; e++) skew_edge(e);
    check("wrap_final", bus.out_bot, 16'h4444);

    // Abort the skewed matmul with reset at E5, then replay it cleanly.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) b_m[r][c] = DW'(c);
    clear();
    for (int e = 0; e < 5; e++) skew_edge(e);
    step(1'b0, left_at(5), top_at(5));
    check("midreset_clear", bus.out_bot, 16'h0000);
    for (int e = 0; e < 3*N-2; e++) skew_edge(e);
    check("midreset_replay", bus.out_bot, 16'hC840);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
